// File: rtl/beat_period_meter.sv
// beat_period_meter
// Measures the spacing between incoming beat strobes and reports it in the
// tick generator's "speed" encoding (cycle distance - 1). It also flags a
// stable beat rate (locked) and a stalled beat stream (timeout).
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   pulse          beat strobe; every high cycle is one event
//   period         last measured period (distance - 1), W bits
//   period_valid   at least one full interval measured since reset/timeout
//   sample_strobe  one-cycle pulse whenever period is updated
//   locked         LOCK_COUNT consecutive matching measurements seen
//   timeout        no pulse for more than 2^W cycles; sticky until next pulse
//
// State table:
//   state       | meaning
//   ST_IDLE     | no event seen since reset
//   ST_ARMED    | one event seen, counting toward first measurement
//   ST_RUN      | at least one period measured, counting
//   ST_TIMEOUT  | counter expired without a pulse, waiting for next event
module beat_period_meter #(
    parameter int W          = 10,
    parameter int LOCK_COUNT = 3,
    parameter int TOL        = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pulse,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         sample_strobe,
    output logic         locked,
    output logic         timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUN     = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W:0]   TOL_W   = (W+1)'(TOL);
    localparam logic [3:0]   LOCK_W  = 4'(LOCK_COUNT);

    state_t       state;
    state_t       state_next;
    logic [W-1:0] since_last;
    logic [3:0]   match_cnt;
    logic [3:0]   match_cnt_next;
    logic         locked_next;
    logic         do_measure;
    logic         do_expire;
    logic         do_arm;
    logic [W:0]   m_ext;
    logic [W:0]   p_ext;
    logic [W:0]   diff;
    logic         is_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Difference is taken one bit wider than the counter so it never wraps.
    assign m_ext    = {1'b0, since_last};
    assign p_ext    = {1'b0, period};
    assign diff     = (m_ext >= p_ext) ? (m_ext - p_ext) : (p_ext - m_ext);
    assign is_match = (diff <= TOL_W);

    always_comb begin
        state_next     = state;
        do_measure     = 1'b0;
        do_expire      = 1'b0;
        do_arm         = 1'b0;
        match_cnt_next = match_cnt;
        locked_next    = locked;

        case (state)
            ST_IDLE, ST_TIMEOUT: begin
                if (pulse) begin
                    do_arm     = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED, ST_RUN: begin
                if (pulse) begin
                    do_measure = 1'b1;
                    state_next = ST_RUN;
                end else if (since_last == CNT_MAX) begin
                    do_expire  = 1'b1;
                    state_next = ST_TIMEOUT;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The first measurement after arming has nothing to compare against.
        if (do_measure) begin
            if (state == ST_RUN && is_match) begin
                match_cnt_next = (match_cnt == LOCK_W) ? match_cnt : match_cnt + 4'd1;
            end else begin
                match_cnt_next = 4'd0;
            end
            locked_next = (match_cnt_next == LOCK_W);
        end else if (do_expire) begin
            match_cnt_next = 4'd0;
            locked_next    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            since_last    <= '0;
            match_cnt     <= 4'd0;
            period        <= '0;
            period_valid  <= 1'b0;
            sample_strobe <= 1'b0;
            locked        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            sample_strobe <= do_measure;
            match_cnt     <= match_cnt_next;
            locked        <= locked_next;

            if (pulse) begin
                since_last <= '0;
            end else if ((state == ST_ARMED || state == ST_RUN) && !do_expire) begin
                since_last <= since_last + 1'b1;
            end

            if (do_measure) begin
                period       <= since_last;
                period_valid <= 1'b1;
            end

            if (do_expire) begin
                timeout      <= 1'b1;
                period_valid <= 1'b0;
            end

            if (do_arm) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beat_period_meter.sv
// tb_beat_period_meter
// Directed bench for beat_period_meter: table-driven pulse spacings with
// hand-computed expected outputs, plus hand-written sequences for timeout,
// continuous pulses, mid-interval reset and tolerance matching (second
// instance with TOL = 1).
module tb_beat_period_meter;

    logic       clk;
    logic       reset;
    logic       pulse;

    logic [9:0] p0, p1;
    logic       v0, v1, s0, s1, l0, l1, t0, t1;

    int n_checks = 0;
    int n_pass   = 0;
    int elapsed  = 0;

    typedef struct {
        int   gap;
        int   e_period;
        logic e_valid;
        logic e_strobe;
        logic e_locked;
        logic e_timeout;
    } vec_t;

    vec_t tab_a [11];
    vec_t tab_e [8];

    beat_period_meter #(.W(10), .LOCK_COUNT(3), .TOL(0)) dut0 (
        .clk(clk), .reset(reset), .pulse(pulse),
        .period(p0), .period_valid(v0), .sample_strobe(s0),
        .locked(l0), .timeout(t0)
    );

    beat_period_meter #(.W(10), .LOCK_COUNT(3), .TOL(1)) dut1 (
        .clk(clk), .reset(reset), .pulse(pulse),
        .period(p1), .period_valid(v1), .sample_strobe(s1),
        .locked(l1), .timeout(t1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        elapsed++;
    endtask

    // Pulse so that its distance from the previous pulse cycle is gap, then
    // stop at the negedge just after the pulse was sampled.
    task automatic do_pulse(input int gap);
        while (elapsed < gap - 1) tick();
        pulse = 1'b1;
        @(negedge clk);
        pulse   = 1'b0;
        elapsed = 0;
    endtask

    task automatic do_reset();
        pulse = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        elapsed = 0;
    endtask

    task automatic read_outs(input int sel, output int p, output int v,
                             output int s, output int l, output int t);
        if (sel == 0) begin
            p = int'(p0); v = int'(v0); s = int'(s0); l = int'(l0); t = int'(t0);
        end else begin
            p = int'(p1); v = int'(v1); s = int'(s1); l = int'(l1); t = int'(t1);
        end
    endtask

    task automatic check_all(input string tag, input int sel, input int e_p,
                             input int e_v, input int e_s, input int e_l, input int e_t);
        int p, v, s, l, t;
        read_outs(sel, p, v, s, l, t);
        check({tag, "_period"}, p, e_p);
        check({tag, "_valid"}, v, e_v);
        check({tag, "_strobe"}, s, e_s);
        check({tag, "_locked"}, l, e_l);
        check({tag, "_timeout"}, t, e_t);
    endtask

    task automatic run_vec(input vec_t vv, input int sel, input string tag);
        do_pulse(vv.gap);
        check_all(tag, sel, vv.e_period, int'(vv.e_valid), int'(vv.e_strobe),
                  int'(vv.e_locked), int'(vv.e_timeout));
    endtask

    initial begin
        int p, v, s, l, t;

        // gap, period, valid, strobe, locked, timeout
        tab_a[0]  = '{5,    0,    1'b0, 1'b0, 1'b0, 1'b0};
        tab_a[1]  = '{513,  512,  1'b1, 1'b1, 1'b0, 1'b0};
        tab_a[2]  = '{513,  512,  1'b1, 1'b1, 1'b0, 1'b0};
        tab_a[3]  = '{513,  512,  1'b1, 1'b1, 1'b0, 1'b0};
        tab_a[4]  = '{513,  512,  1'b1, 1'b1, 1'b1, 1'b0};
        tab_a[5]  = '{513,  512,  1'b1, 1'b1, 1'b1, 1'b0};
        tab_a[6]  = '{769,  768,  1'b1, 1'b1, 1'b0, 1'b0};
        tab_a[7]  = '{769,  768,  1'b1, 1'b1, 1'b0, 1'b0};
        tab_a[8]  = '{769,  768,  1'b1, 1'b1, 1'b0, 1'b0};
        tab_a[9]  = '{769,  768,  1'b1, 1'b1, 1'b1, 1'b0};
        tab_a[10] = '{1024, 1023, 1'b1, 1'b1, 1'b0, 1'b0};

        tab_e[0] = '{1,   0,   1'b0, 1'b0, 1'b0, 1'b0};
        tab_e[1] = '{512, 511, 1'b1, 1'b1, 1'b0, 1'b0};
        tab_e[2] = '{513, 512, 1'b1, 1'b1, 1'b0, 1'b0};
        tab_e[3] = '{512, 511, 1'b1, 1'b1, 1'b0, 1'b0};
        tab_e[4] = '{513, 512, 1'b1, 1'b1, 1'b1, 1'b0};
        tab_e[5] = '{512, 511, 1'b1, 1'b1, 1'b1, 1'b0};
        tab_e[6] = '{513, 512, 1'b1, 1'b1, 1'b1, 1'b0};
        tab_e[7] = '{515, 514, 1'b1, 1'b1, 1'b0, 1'b0};

        pulse = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        elapsed = 0;
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // 512 lock, retarget to 768 and relock, then max measurable spacing
        for (int i = 0; i < 11; i++) begin
            run_vec(tab_a[i], 0, $sformatf("a%0d", i));
            if (i == 1) begin
                tick();
                check("a1_strobe_drop", int'(s0), 0);
            end
        end

        // silence after the 1024-spacing pulse
        while (elapsed < 1023) tick();
        check_all("to_before", 0, 1023, 1, 0, 0, 0);
        tick();
        check_all("to_expire", 0, 1023, 0, 0, 0, 1);
        repeat (30) tick();
        check("to_sticky", int'(t0), 1);
        do_pulse(1);
        check_all("to_rearm", 0, 1023, 0, 0, 0, 0);
        do_pulse(100);
        check_all("to_fresh", 0, 99, 1, 1, 0, 0);

        // pulse held high continuously
        do_reset();
        pulse = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("cont%0d_strobe", i), int'(s0), (i >= 2) ? 1 : 0);
            check($sformatf("cont%0d_valid", i), int'(v0), (i >= 2) ? 1 : 0);
            check($sformatf("cont%0d_locked", i), int'(l0), (i >= 5) ? 1 : 0);
        end
        pulse   = 1'b0;
        elapsed = 0;
        tick();
        check("cont_strobe_end", int'(s0), 0);
        check("cont_period", int'(p0), 0);

        // reset midway through an interval, with pulse high during reset
        do_reset();
        do_pulse(1);
        do_pulse(513);
        do_pulse(513);
        check("mid_pre_period", int'(p0), 512);
        repeat (256) tick();
        reset = 1'b1;
        pulse = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        pulse   = 1'b0;
        elapsed = 0;
        check_all("mid_reset", 0, 0, 0, 0, 0, 0);
        do_pulse(300);
        check_all("mid_arm", 0, 0, 0, 0, 0, 0);
        do_pulse(513);
        check_all("mid_meas", 0, 512, 1, 1, 0, 0);

        // tolerance: alternating 511/512 locks with TOL = 1 only
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_vec(tab_e[i], 1, $sformatf("tol%0d", i));
            if (i == 4) check("tol0_locked_strict", int'(l0), 0);
        end
        read_outs(1, p, v, s, l, t);
        tick();
        check("tol_strobe_drop", int'(s1), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/beat_period_meter.md
Name: beat_period_meter

Overview:
- Receive-side counterpart of the rhythm game's tick generator, which emits a one-cycle enable strobe every speed+1 clocks.
- Measures the spacing between incoming strobes and reports it in the same encoding as the generator's speed input: measured value = cycle distance − 1.
- Flags when the beat rate is stable (locked) and when strobes have stopped (timeout).
- Used for tempo detection on tap/beat inputs and for self-checking tick generators in system benches.

Parameters:
- W, 10, width of period counter and period output; max measurable period 2^W−1.
- LOCK_COUNT, 3, consecutive matching measurements required to assert locked (1..15).
- TOL, 0, max absolute difference between successive measurements that still counts as a match.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset; clock clk
- pulse  input  1  beat strobe; every cycle sampled high is one event (no edge detection)
- period  output  W  last measured period (distance − 1)
- period_valid  output  1  high once at least one full interval has been measured since reset/timeout
- sample_strobe  output  1  one-cycle pulse when period is updated
- locked  output  1  stable-rate indicator
- timeout  output  1  no pulse for longer than 2^W cycles; sticky until the next pulse

Behaviour:
- Reset: all outputs 0; internal counters 0; state IDLE. Reset overrides pulse in the same cycle.
- States:
  - IDLE: no event seen.
  - ARMED: one event seen, counting.
  - RUN: at least one period measured.
  - TIMEOUT: counter expired.
- since_last counter (W bits):
  - Loads 0 on a pulse cycle.
  - Otherwise increments by 1 in ARMED/RUN.
  - Holds in IDLE/TIMEOUT.
  - Value at the k-th cycle after a pulse is k−1.
- IDLE + pulse → ARMED; no outputs change.
- ARMED/RUN + pulse: m = since_last.
  - Next cycle: period = m, period_valid = 1, sample_strobe = 1 for exactly one cycle.
  - State → RUN.
  - Latency: outputs visible the cycle after the pulse cycle.
- Match logic, on each measurement in RUN (not on the first measurement after ARMED):
  - Match if |m − previous period| ≤ TOL. Compute in W+1 bits; no wrap.
  - On match: match_cnt increments, saturating at LOCK_COUNT.
  - On mismatch: match_cnt = 0 and locked = 0 in the same update as period.
  - locked = 1 when match_cnt == LOCK_COUNT, asserted in the same cycle as that sample_strobe. This requires LOCK_COUNT+1 consistent measurements.
- Back-to-back pulses every cycle give m = 0 each cycle; sample_strobe stays high continuously.
- Overflow:
  - since_last == 2^W−1 with pulse high is a valid measurement of 2^W−1.
  - since_last == 2^W−1 with pulse low → TIMEOUT next cycle: timeout = 1, period_valid = 0, locked = 0, match_cnt = 0. period holds its last value.
- TIMEOUT + pulse → ARMED, timeout = 0 next cycle. The next pulse yields a fresh first measurement.
- Reset mid-interval discards the partial count; the first pulse after reset only arms.

Test Plan:
- Reset, then pulse every 513 cycles for 6 pulses → no strobe on pulse 1; from pulse 2, period = 512 and period_valid = 1 one cycle after each pulse; locked = 1 after pulse 5 (LOCK_COUNT = 3).
- pulse held high continuously → from the second cycle, period = 0 and sample_strobe = 1 every cycle; locked after 4 measurements.
- Pulse, then another pulse 1024 cycles later → period = 1023, valid, no timeout. Pulse, then silence → timeout = 1 and period_valid = 0 1025 cycles after the pulse. Next pulse clears timeout; pulse after that gives a fresh measurement.
- Locked at 512, then switch to a 769-cycle spacing → first sample gives period = 768 and locked = 0 in the same cycle; relock after 3 further matching samples.
- Assert reset for 1 cycle midway between 512-period pulses → all outputs 0. Next pulse arms only; the following pulse reports the true spacing.
- TOL = 1, spacings alternating 512/513 (m = 511/512) → locked stays 1. A single m = 514 → locked drops.
